bufm_id_mgr: RTL and testbench
==============================

// Module: bufm_id_mgr
// PURPOSE
// - Free-list controller for packet-buffer IDs in the buffer manager (bufm).
// - Hands out a free buffer ID to the packet writer in the same cycle it is requested.
// - Reclaims IDs returned by the output side after transmission.
// - Drives bufm_ID_count, the idle-ID count pac uses for admission and traffic regulation.
// - Flags illegal releases and tracks the low-water mark of free IDs.
// PARAMETERS
// - ID_NUM  16  number of buffer IDs managed; any value 2..16 (IDs 0..ID_NUM-1)
// - ID_W    4   width of an ID; ID_NUM <= 2**ID_W
// PORTS
// - clk              in   1     clock
// - rst_n            in   1     reset, asynchronous, active-low
// - alloc_req        in   1     level: requester wants one ID this cycle
// - alloc_gnt        out  1     comb: ID granted this cycle (alloc_id valid)
// - alloc_id         out  ID_W  head of free list; valid only when alloc_gnt=1
// - release_wr       in   1     one-cycle strobe: return release_id to free list
// - release_id       in   ID_W  ID being returned
// - bufm_ID_count    out  ID_W+1  registered number of free IDs
// - init_done        out  1     1 once the free list is loaded
// - err_release      out  1     one-cycle pulse: release dropped (dup/out-of-range/INIT)
// - min_free         out  ID_W+1  lowest bufm_ID_count seen since init_done
// BEHAVIOUR
// - Storage:
//   - Circular FIFO fifo[ID_NUM] x ID_W with rd_ptr and wr_ptr.
//   - Pointers wrap ID_NUM-1 -> 0; no power-of-2 requirement.
//   - Bitmap used[ID_NUM]; bit=1 means the ID is allocated.
// - Reset values:
//   - FSM = INIT; pointers, count, bitmap, init_done, err_release all 0.
//   - min_free = ID_NUM.
//   - alloc_gnt = 0 and alloc_id = fifo[rd_ptr], don't-care while alloc_gnt=0.
// - FSM states: INIT, RUN.
//   - INIT: one write per cycle, fifo[i] <= i for i = 0..ID_NUM-1; wr_ptr and count +1 per cycle.
//   - INIT -> RUN after the write of ID_NUM-1.
//   - INIT lasts exactly ID_NUM cycles; init_done goes 1 with RUN entry.
//   - INIT: alloc_gnt forced 0.
//   - INIT: release_wr dropped, err_release pulses next cycle.
//   - RUN: no exit except reset.
// - Allocate:
//   - alloc_gnt = alloc_req & RUN & (bufm_ID_count != 0); zero latency.
//   - On gnt: rd_ptr+1; used[alloc_id] <= 1; count -1 next cycle.
//   - One ID per cycle while alloc_req stays high.
//   - A requester wanting exactly one ID drops alloc_req in the cycle after alloc_gnt.
// - Release:
//   - Accepted if RUN & release_id < ID_NUM & used[release_id] = 1.
//   - Accept action: fifo[wr_ptr] <= id; wr_ptr+1; used <= 0; count +1 next cycle.
//   - Otherwise dropped with err_release = 1 in the next cycle; no state change.
// - Simultaneous grant + accepted release:
//   - Both happen; count unchanged.
//   - Released ID is queued at tail and never granted in its release cycle.
// - Empty (count = 0):
//   - alloc_gnt = 0 even if a release is accepted that cycle.
//   - Grant resumes the next cycle with the released ID.
// - Full (count = ID_NUM): an accepted release is impossible (bitmap all 0); dup check covers it.
// - Releasing an ID granted in the same cycle (used not yet set): dropped as duplicate.
// - Width rules:
//   - count is ID_W+1 bits and is never <0 or >ID_NUM by construction.
//   - min_free <= count whenever RUN & count < min_free.
// - Reset mid-operation:
//   - Asynchronously returns to INIT; all IDs reclaimed; outstanding allocations forgotten.
//   - Holders (pac/ibm/goe) share rst_n.
// TESTING
// - T1 (reset release, ID_NUM=16):
//   - init_done=1 exactly 16 cycles after rst_n rises; bufm_ID_count=16.
//   - 3 cycles of alloc_req give gnt with ids 0,1,2; then count=13.
// - T2 (exhaust):
//   - Hold alloc_req 17 cycles: 16 grants (ids 0..15), 17th cycle alloc_gnt=0.
//   - Then count=0 and min_free=0.
// - T3 (empty + release):
//   - From T2, release_id=5 with alloc_req=1: no gnt that cycle.
//   - Next cycle count=1, gnt with id 5, then count=0.
// - T4 (simultaneous grant + release):
//   - count=8, same cycle alloc gnt and release of allocated id 3.
//   - count stays 8; id 3 is granted only after the 8 queued IDs.
// - T5 (illegal releases):
//   - Release an already-free id 7 -> err_release pulse, count unchanged.
//   - ID_NUM=12, release id 13 -> err_release pulse.
//   - Release during INIT -> err_release pulse.
// - T6 (reset mid-op):
//   - With 10 IDs allocated, pulse rst_n low 1 cycle: alloc_gnt=0 and count=0 immediately.
//   - After 16 cycles, count=16 and the first grant returns id 0.

Source files
------------

// File: rtl/bufm_id_mgr_if.sv
// Request/release handshake and status bus between the buffer-ID free list
// and its users (packet writer, output side, admission control).
interface bufm_id_mgr_if #(
  parameter int ID_W = 4
);
  logic            alloc_req;
  logic            alloc_gnt;
  logic [ID_W-1:0] alloc_id;
  logic            release_wr;
  logic [ID_W-1:0] release_id;
  logic [ID_W:0]   bufm_ID_count;
  logic            init_done;
  logic            err_release;
  logic [ID_W:0]   min_free;

  modport master (
    output alloc_req, release_wr, release_id,
    input  alloc_gnt, alloc_id, bufm_ID_count, init_done, err_release, min_free
  );

  modport slave (
    input  alloc_req, release_wr, release_id,
    output alloc_gnt, alloc_id, bufm_ID_count, init_done, err_release, min_free
  );
endinterface

// File: rtl/bufm_id_mgr.sv
// Free-list controller for packet-buffer IDs: zero-latency grant from a circular
// FIFO of free IDs, bitmap-checked release, free count and low-water mark.
module bufm_id_mgr #(
  parameter int ID_NUM = 16,
  parameter int ID_W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bufm_id_mgr_if.slave bus
);
  localparam int                PTR_W    = (ID_NUM > 1) ? $clog2(ID_NUM) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(ID_NUM - 1);
  localparam logic [ID_W:0]     FULL_CNT = (ID_W + 1)'(ID_NUM);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ID_W:0]          count_q, count_d;
  logic [ID_W:0]          min_free_q, min_free_d;
  logic [(2**ID_W)-1:0]   used_q, used_d;
  logic                   init_done_q, init_done_d;
  logic                   err_q, err_d;

  logic [ID_W-1:0]        fifo_q [ID_NUM];
  logic                   fifo_we;
  logic [PTR_W-1:0]       fifo_waddr;
  logic [ID_W-1:0]        fifo_wdata;

  logic                   run;
  logic                   gnt;
  logic                   id_in_range;
  logic                   rel_ok;
  logic [ID_W-1:0]        head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // When the ID field exactly covers ID_NUM every encoding is a valid ID.
  generate
    if (ID_NUM == (2**ID_W)) begin : g_full_range
      assign id_in_range = 1'b1;
    end else begin : g_part_range
      assign id_in_range = ({1'b0, bus.release_id} < FULL_CNT);
    end
  endgenerate

  assign run     = (state_q == ST_RUN);
  assign head_id = fifo_q[rd_ptr_q];
  assign gnt     = bus.alloc_req & run & (count_q != '0);
  // An ID granted this cycle still reads as free, so releasing it is a duplicate.
  assign rel_ok  = bus.release_wr & run & id_in_range & used_q[bus.release_id];

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    min_free_d  = min_free_q;
    used_d      = used_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    fifo_we     = 1'b0;
    fifo_waddr  = wr_ptr_q;
    fifo_wdata  = bus.release_id;
    case (state_q)
      ST_INIT: begin
        fifo_we    = 1'b1;
        fifo_wdata = ID_W'(wr_ptr_q);
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        count_d    = count_q + (ID_W + 1)'(1);
        err_d      = bus.release_wr;
        if (wr_ptr_q == LAST_PTR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (gnt) begin
          rd_ptr_d        = ptr_inc(rd_ptr_q);
          used_d[head_id] = 1'b1;
        end
        if (rel_ok) begin
          fifo_we                 = 1'b1;
          wr_ptr_d                = ptr_inc(wr_ptr_q);
          used_d[bus.release_id]  = 1'b0;
        end
        err_d = bus.release_wr & ~rel_ok;
        case ({gnt, rel_ok})
          2'b10:   count_d = count_q - (ID_W + 1)'(1);
          2'b01:   count_d = count_q + (ID_W + 1)'(1);
          default: count_d = count_q;
        endcase
        if (count_q < min_free_q) min_free_d = count_q;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      min_free_q  <= FULL_CNT;
      used_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      min_free_q  <= min_free_d;
      used_q      <= used_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Contents need no reset: INIT rewrites every entry before any read matters.
  always_ff @(posedge clk) begin
    if (fifo_we) fifo_q[fifo_waddr] <= fifo_wdata;
  end

  assign bus.alloc_gnt     = gnt;
  assign bus.alloc_id      = head_id;
  assign bus.bufm_ID_count = count_q;
  assign bus.init_done     = init_done_q;
  assign bus.err_release   = err_q;
  assign bus.min_free      = min_free_q;
endmodule

// File: tb/tb_bufm_id_mgr.sv
// Scoreboard bench for bufm_id_mgr: a free-list queue model predicts grants and
// release errors; a negedge monitor pops and compares whenever the DUT presents them.
module tb_bufm_id_mgr;
  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bufm_id_mgr_if #(.ID_W(4)) u ();
  bufm_id_mgr_if #(.ID_W(4)) u12 ();

  bufm_id_mgr #(.ID_NUM(16), .ID_W(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(u));
  bufm_id_mgr #(.ID_NUM(12), .ID_W(4)) dut12 (.clk(clk), .rst_n(rst_n), .bus(u12));

  typedef struct {
    int cyc;
    int id;
  } gnt_t;

  gnt_t exp_gnt[$];
  int   exp_err[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // reference model: ordered free list plus allocation flags
  int   free_q[$];
  bit   alloc_m[N];
  bit   running;
  int   init_cnt;
  int   min_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1: drive one cycle of inputs, predict, advance one clock.
  task automatic step(input bit req, input bit rel, input int rid);
    bit         g;
    bit         acc;
    int         gid;
    logic [3:0] rid4;
    gnt_t       e;
    rid4 = 4'(rid);
    u.alloc_req  = req;
    u.release_wr = rel;
    u.release_id = rid4;
    acc = rel && running && alloc_m[rid4];
    g   = req && running && (free_q.size() > 0);
    if (g) begin
      gid = free_q.pop_front();
      alloc_m[gid] = 1'b1;
      e.cyc = cyc;
      e.id  = gid;
      exp_gnt.push_back(e);
    end
    if (rel && !acc) exp_err.push_back(cyc + 1);
    if (acc) begin
      alloc_m[rid4] = 1'b0;
      free_q.push_back(int'(rid4));
    end
    @(posedge clk);
    #1;
    if (!running) begin
      init_cnt++;
      if (init_cnt == N) begin
        running = 1'b1;
        for (int i = 0; i < N; i++) free_q.push_back(i);
      end
    end else if (free_q.size() < min_m) begin
      min_m = free_q.size();
    end
    chk("count", int'(u.bufm_ID_count), running ? free_q.size() : init_cnt);
    chk("init_done", int'(u.init_done), int'(running));
  endtask

  task automatic do_reset(input bit req);
    u.alloc_req  = req;
    u.release_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'(u.alloc_gnt), 0);
    chk("rst_count", int'(u.bufm_ID_count), 0);
    chk("rst_init_done", int'(u.init_done), 0);
    chk("rst_min_free", int'(u.min_free), N);
    running  = 1'b0;
    init_cnt = 0;
    min_m    = N;
    free_q.delete();
    exp_gnt.delete();
    exp_err.delete();
    for (int i = 0; i < N; i++) alloc_m[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor: consumes expected responses whenever the DUT presents one
  always @(negedge clk) begin
    gnt_t e;
    int   ec;
    if (rst_n && u.alloc_gnt) begin
      if (exp_gnt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got id %0d at cycle %0d expected no grant", u.alloc_id, cyc);
      end else begin
        e = exp_gnt.pop_front();
        chk("grant_cycle", cyc, e.cyc);
        chk("grant_id", int'(u.alloc_id), e.id);
      end
    end
    if (rst_n && u.err_release) begin
      if (exp_err.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_err_release: got pulse at cycle %0d expected none", cyc);
      end else begin
        ec = exp_err.pop_front();
        chk("err_cycle", cyc, ec);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    u.alloc_req    = 1'b0;
    u.release_wr   = 1'b0;
    u.release_id   = '0;
    u12.alloc_req  = 1'b0;
    u12.release_wr = 1'b0;
    u12.release_id = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // T1: INIT with a release mid-way (dropped), then three single grants
    for (int i = 0; i < N; i++) step(1'b0, i == 5, 2);
    chk("min_free_after_init", int'(u.min_free), N);
    chk("dut12_count", int'(u12.bufm_ID_count), 12);
    chk("dut12_init_done", int'(u12.init_done), 1);
    chk("dut12_min_free", int'(u12.min_free), 12);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // T2: exhaust, one extra request cycle with no grant
    repeat (14) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("min_free_empty", int'(u.min_free), min_m);

    // T3: release into an empty list while requesting
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // T4: refill to 8, then simultaneous grant + release of id 3
    for (int id = 8; id < 16; id++) step(1'b0, 1'b1, id);
    step(1'b1, 1'b1, 3);
    repeat (9) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // T5: duplicate release, release of an ID granted in the same cycle, out-of-range on ID_NUM=12
    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b1, 7);
    step(1'b1, 1'b1, 7);
    step(1'b0, 1'b0, 0);
    u12.release_wr = 1'b1;
    u12.release_id = 4'd13;
    step(1'b0, 1'b0, 0);
    chk("dut12_err_range", int'(u12.err_release), 1);
    chk("dut12_count_kept", int'(u12.bufm_ID_count), 12);
    u12.release_wr = 1'b0;
    step(1'b0, 1'b0, 0);
    chk("dut12_err_clear", int'(u12.err_release), 0);

    // T6: reset with 10 IDs outstanding, requests held through INIT
    do_reset(1'b0);
    repeat (N) step(1'b0, 1'b0, 0);
    repeat (10) step(1'b1, 1'b0, 0);
    do_reset(1'b1);
    repeat (N) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // random traffic against the model
    repeat (500) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, int'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("min_free_random", int'(u.min_free), min_m);
    chk("pending_grants", exp_gnt.size(), 0);
    chk("pending_errs", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
